// File: rtl/output_axi_writer.sv
// Drains packed rows from the 4-slot row buffer and writes them to DDR as AXI4 INCR bursts.
// First W beat 2 cycles after AW accept, then 1/cycle; AW/W/B all stall cleanly, buffer reads run at most 2 ahead.
module output_axi_writer #(
    parameter int C_S_AXI_ID_WIDTH   = 3,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int C_S_AXI_BURST_LEN  = 8,
    parameter int MAX_OUTSTANDING    = 15
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            Start,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   axi_address,
    input  logic [6:0]                      words_per_row,
    input  logic [15:0]                     total_rows,
    input  logic [15:0]                     row_stride,
    input  logic                            row_complete,
    output logic                            row_release,
    output logic                            busy,
    output logic                            done,
    output logic                            wr_error,
    output logic [7:0]                      addrb,
    output logic                            enb,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   doutb,
    output logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_awid,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_axi_awaddr,
    output logic [7:0]                      M_axi_awlen,
    output logic [2:0]                      M_axi_awsize,
    output logic [1:0]                      M_axi_awburst,
    output logic                            M_axi_awlock,
    output logic [3:0]                      M_axi_awcache,
    output logic [2:0]                      M_axi_awprot,
    output logic [3:0]                      M_axi_awqos,
    output logic                            M_axi_awvalid,
    input  logic                            M_axi_awready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   M_axi_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_axi_wstrb,
    output logic                            M_axi_wlast,
    output logic                            M_axi_wvalid,
    input  logic                            M_axi_wready,
    input  logic [1:0]                      M_axi_bresp,
    input  logic                            M_axi_bvalid,
    output logic                            M_axi_bready
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_ROW, S_ADDR, S_DATA, S_DRAIN, S_DONE} state_t;
    state_t state_q, state_d;

    logic [6:0]    wpr_q, word_idx_q;
    logic [15:0]   total_q, stride_q, rows_done_q;
    logic [AW-1:0] row_addr_q, awaddr_q;
    logic [7:0]    awlen_q;
    logic [4:0]    rd_left_q, beats_left_q;
    logic [5:0]    rd_ptr_q;
    logic          in_flight_q;
    logic [DW-1:0] fifo_mem_q [2];
    logic          fifo_wr_q, fifo_rd_q;
    logic [1:0]    fifo_cnt_q;
    logic [2:0]    rows_avail_q;
    logic [1:0]    slot_q;
    logic          release_q;
    logic [3:0]    outstanding_q;
    logic          wr_error_q;

    logic       start_ok, aw_fire, w_vld, w_fire, b_fire, last_beat, row_words_left, more_rows;
    logic       load_aw, overflow;
    logic [2:0] avail_now;
    logic [6:0] rem, burst_words;

    assign start_ok       = Start && (state_q == S_IDLE || state_q == S_DONE);
    assign aw_fire        = M_axi_awvalid && M_axi_awready;
    assign w_vld          = fifo_cnt_q != 2'd0;
    assign w_fire         = w_vld && M_axi_wready;
    assign b_fire         = M_axi_bvalid && M_axi_bready;
    assign last_beat      = w_fire && beats_left_q == 5'd1;
    assign row_words_left = word_idx_q < wpr_q;
    assign more_rows      = ({1'b0, rows_done_q} + 17'd1) < {1'b0, total_q};
    // The release pulse has not yet reached rows_avail, so discount it here.
    assign avail_now      = rows_avail_q - {2'b0, release_q};
    assign rem            = wpr_q - word_idx_q;
    assign burst_words    = (rem > 7'(C_S_AXI_BURST_LEN)) ? 7'(C_S_AXI_BURST_LEN) : rem;
    assign overflow       = row_complete && !release_q && rows_avail_q == 3'd4;

    always_comb begin
        state_d       = state_q;
        load_aw       = 1'b0;
        M_axi_awvalid = 1'b0;
        enb           = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: if (start_ok) state_d = (total_rows == 16'd0) ? S_DRAIN : S_WAIT_ROW;
            S_WAIT_ROW: if (avail_now != 3'd0) begin
                state_d = S_ADDR;
                load_aw = 1'b1;
            end
            S_ADDR: begin
                M_axi_awvalid = outstanding_q < 4'(MAX_OUTSTANDING);
                if (aw_fire) state_d = S_DATA;
            end
            S_DATA: begin
                // Pop this cycle frees a slot, which keeps beats back-to-back.
                enb = rd_left_q != 5'd0 &&
                      ({1'b0, fifo_cnt_q} + {2'b0, in_flight_q}) < (3'd2 + {2'b0, w_fire});
                if (last_beat) begin
                    if (row_words_left) begin
                        state_d = S_ADDR;
                        load_aw = 1'b1;
                    end else begin
                        state_d = more_rows ? S_WAIT_ROW : S_DRAIN;
                    end
                end
            end
            S_DRAIN: if (outstanding_q == 4'd0) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            wpr_q         <= '0;
            word_idx_q    <= '0;
            total_q       <= '0;
            stride_q      <= '0;
            rows_done_q   <= '0;
            row_addr_q    <= '0;
            awaddr_q      <= '0;
            awlen_q       <= '0;
            rd_left_q     <= '0;
            beats_left_q  <= '0;
            rd_ptr_q      <= '0;
            in_flight_q   <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_wr_q     <= 1'b0;
            fifo_rd_q     <= 1'b0;
            fifo_cnt_q    <= '0;
            rows_avail_q  <= '0;
            slot_q        <= '0;
            release_q     <= 1'b0;
            outstanding_q <= '0;
            wr_error_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            release_q <= 1'b0;
            if (start_ok) begin
                wpr_q       <= words_per_row;
                total_q     <= total_rows;
                stride_q    <= row_stride;
                row_addr_q  <= axi_address;
                rows_done_q <= '0;
                word_idx_q  <= '0;
            end
            if (load_aw) begin
                awaddr_q <= row_addr_q + {{(AW-10){1'b0}}, word_idx_q, 3'b000};
                awlen_q  <= 8'(burst_words - 7'd1);
            end
            if (enb) begin
                rd_left_q <= rd_left_q - 5'd1;
                rd_ptr_q  <= rd_ptr_q + 6'd1;
            end
            in_flight_q <= enb;
            if (in_flight_q) begin
                fifo_mem_q[fifo_wr_q] <= doutb;
                fifo_wr_q             <= ~fifo_wr_q;
            end
            if (w_fire) begin
                fifo_rd_q    <= ~fifo_rd_q;
                beats_left_q <= beats_left_q - 5'd1;
            end
            fifo_cnt_q <= 2'(fifo_cnt_q + {1'b0, in_flight_q} - {1'b0, w_fire});
            if (aw_fire) begin
                word_idx_q   <= word_idx_q + {3'b0, awlen_q[3:0]} + 7'd1;
                rd_left_q    <= {1'b0, awlen_q[3:0]} + 5'd1;
                beats_left_q <= {1'b0, awlen_q[3:0]} + 5'd1;
                rd_ptr_q     <= word_idx_q[5:0];
            end
            if (last_beat && !row_words_left) begin
                release_q   <= 1'b1;
                rows_done_q <= rows_done_q + 16'd1;
                row_addr_q  <= row_addr_q + {{(AW-16){1'b0}}, stride_q};
                word_idx_q  <= '0;
            end
            case ({row_complete, release_q})
                2'b10:   if (!overflow) rows_avail_q <= rows_avail_q + 3'd1;
                2'b01:   rows_avail_q <= rows_avail_q - 3'd1;
                default: rows_avail_q <= rows_avail_q;
            endcase
            if (release_q) slot_q <= slot_q + 2'd1;
            case ({aw_fire, b_fire})
                2'b10:   outstanding_q <= outstanding_q + 4'd1;
                2'b01:   outstanding_q <= outstanding_q - 4'd1;
                default: outstanding_q <= outstanding_q;
            endcase
            if (start_ok) wr_error_q <= 1'b0;
            if ((b_fire && M_axi_bresp != 2'b00) || overflow) wr_error_q <= 1'b1;
        end
    end

    assign row_release   = release_q;
    assign busy          = state_q inside {S_WAIT_ROW, S_ADDR, S_DATA, S_DRAIN};
    assign done          = state_q == S_DONE;
    assign wr_error      = wr_error_q;
    assign addrb         = {slot_q, rd_ptr_q};
    assign M_axi_awid    = '0;
    assign M_axi_awaddr  = awaddr_q;
    assign M_axi_awlen   = awlen_q;
    assign M_axi_awsize  = 3'd3;
    assign M_axi_awburst = 2'b01;
    assign M_axi_awlock  = 1'b0;
    assign M_axi_awcache = 4'b0011;
    assign M_axi_awprot  = 3'b000;
    assign M_axi_awqos   = 4'b0000;
    assign M_axi_wdata   = fifo_mem_q[fifo_rd_q];
    assign M_axi_wstrb   = {(DW/8){w_vld}};
    assign M_axi_wlast   = w_vld && beats_left_q == 5'd1;
    assign M_axi_wvalid  = w_vld;
    assign M_axi_bready  = outstanding_q != 4'd0;
endmodule

// File: tb/tb_output_axi_writer.sv
// Directed bench for output_axi_writer: buffer model, AXI slave with optional random stalls,
// scoreboard of AW/W traffic against hand-derived burst layouts.
module tb_output_axi_writer;
    localparam int BL = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [31:0] axi_address = '0;
    logic [6:0]  words_per_row = '0;
    logic [15:0] total_rows = '0, row_stride = '0;
    logic        row_complete = 1'b0;
    logic        row_release, busy, done, wr_error, enb;
    logic [7:0]  addrb;
    logic [63:0] doutb = '0;
    logic [2:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache, awqos;
    logic        awvalid, awready = 1'b1;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready = 1'b1;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0, bready;

    always #5 clk = ~clk;

    output_axi_writer dut (
        .clk(clk), .reset_n(reset_n), .Start(Start), .axi_address(axi_address),
        .words_per_row(words_per_row), .total_rows(total_rows), .row_stride(row_stride),
        .row_complete(row_complete), .row_release(row_release), .busy(busy), .done(done),
        .wr_error(wr_error), .addrb(addrb), .enb(enb), .doutb(doutb),
        .M_axi_awid(awid), .M_axi_awaddr(awaddr), .M_axi_awlen(awlen), .M_axi_awsize(awsize),
        .M_axi_awburst(awburst), .M_axi_awlock(awlock), .M_axi_awcache(awcache),
        .M_axi_awprot(awprot), .M_axi_awqos(awqos), .M_axi_awvalid(awvalid),
        .M_axi_awready(awready), .M_axi_wdata(wdata), .M_axi_wstrb(wstrb), .M_axi_wlast(wlast),
        .M_axi_wvalid(wvalid), .M_axi_wready(wready), .M_axi_bresp(bresp),
        .M_axi_bvalid(bvalid), .M_axi_bready(bready)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] buf_word(input logic [7:0] a);
        return 64'hA5A5_0000_0000_0000 ^ ({56'd0, a} * 64'h0000_0101_0003_0007);
    endfunction

    always @(posedge clk) if (enb) doutb <= buf_word(addrb);

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Traffic monitor: owns the scoreboard queues and stall-stability checks.
    logic [31:0] awa_q[$];
    logic [7:0]  awl_q[$];
    logic [63:0] wd_q[$];
    logic        wl_q[$];
    int          wc_q[$];
    int          aw_cnt = 0, rel_cnt = 0;
    logic        aw_stall = 1'b0, w_stall = 1'b0;
    logic [31:0] p_awaddr;
    logic [7:0]  p_awlen;
    logic [63:0] p_wdata;
    logic        p_wlast;

    always @(negedge clk) begin
        if (!reset_n) begin
            aw_stall = 1'b0; w_stall = 1'b0;
            awa_q.delete(); awl_q.delete(); wd_q.delete(); wl_q.delete(); wc_q.delete();
            aw_cnt = 0; rel_cnt = 0;
        end else begin
            if (aw_stall) begin
                chk("aw_hold_valid", awvalid, 1);
                chk("aw_hold_addr", awaddr, p_awaddr);
                chk("aw_hold_len", awlen, p_awlen);
            end
            if (w_stall) begin
                chk("w_hold_valid", wvalid, 1);
                chk("w_hold_data", wdata, p_wdata);
                chk("w_hold_last", wlast, p_wlast);
            end
            if (awvalid && awready) begin
                awa_q.push_back(awaddr); awl_q.push_back(awlen); aw_cnt++;
            end
            if (wvalid) chk("wstrb", wstrb, 8'hFF);
            if (wvalid && wready) begin
                wd_q.push_back(wdata); wl_q.push_back(wlast); wc_q.push_back(cyc);
            end
            if (bvalid) chk("bready", bready, 1);
            if (row_release) rel_cnt++;
            aw_stall = awvalid && !awready; p_awaddr = awaddr; p_awlen = awlen;
            w_stall = wvalid && !wready;    p_wdata = wdata;   p_wlast = wlast;
        end
    end

    logic rnd_mode = 1'b0, b_hold = 1'b0;
    int   err_idx = -1, b_sent = 0;

    always @(posedge clk) begin
        #1;
        awready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // One-cycle B response per accepted AW, optionally delayed or held off.
    always @(posedge clk) begin
        #1;
        bvalid = 1'b0; bresp = 2'b00;
        if (!reset_n) b_sent = 0;
        else if (aw_cnt > b_sent && !b_hold && (!rnd_mode || $urandom_range(0, 2) == 0)) begin
            bvalid = 1'b1;
            bresp  = (b_sent == err_idx) ? 2'b10 : 2'b00;
            b_sent++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            row_complete = 1'b1; tick();
        end
        row_complete = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] base, input int wpr, input int rows, input logic [31:0] stride);
        axi_address = base; words_per_row = 7'(wpr); total_rows = 16'(rows); row_stride = 16'(stride);
        Start = 1'b1; tick(); Start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin tick(); k++; end
        chk(tag, done, 1);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_awvalid"}, awvalid, 0);  chk({tag, "_awaddr"}, awaddr, 0);
        chk({tag, "_awlen"}, awlen, 0);      chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_wdata"}, wdata, 0);      chk({tag, "_wlast"}, wlast, 0);
        chk({tag, "_wstrb"}, wstrb, 0);      chk({tag, "_enb"}, enb, 0);
        chk({tag, "_addrb"}, addrb, 0);      chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);        chk({tag, "_wr_error"}, wr_error, 0);
        chk({tag, "_release"}, row_release, 0); chk({tag, "_bready"}, bready, 0);
    endtask

    task automatic verify(input logic [31:0] base, input int wpr, input int rows, input logic [31:0] stride,
                          input int slot0, input int aw0, input int w0, input int rel0, input bit contig);
        int ai = aw0, wi = w0;
        for (int r = 0; r < rows; r++) begin
            for (int w = 0; w < wpr; w += BL) begin
                int len = ((wpr - w) > BL) ? BL : (wpr - w);
                logic [31:0] ea = base + 32'(r) * stride + 32'(w * 8);
                if (ai < awa_q.size()) begin
                    chk("aw_addr", awa_q[ai], ea);
                    chk("aw_len", awl_q[ai], len - 1);
                end
                ai++;
                for (int b = 0; b < len; b++) begin
                    logic [7:0] a = {2'((slot0 + r) % 4), 6'(w + b)};
                    if (wi < wd_q.size()) begin
                        chk("beat_data", wd_q[wi], buf_word(a));
                        chk("beat_last", wl_q[wi], b == len - 1);
                        if (contig && b > 0) chk("beat_gap", wc_q[wi] - wc_q[wi-1], 1);
                    end
                    wi++;
                end
            end
        end
        chk("aw_total", awa_q.size() - aw0, ai - aw0);
        chk("beat_total", wd_q.size() - w0, wi - w0);
        chk("releases", rel_cnt - rel0, rows);
    endtask

    int slot_next = 0;

    task automatic run_simple(input logic [31:0] base, input int wpr, input int rows, input logic [31:0] stride);
        int aw0 = awa_q.size(), w0 = wd_q.size(), rel0 = rel_cnt;
        feed(rows);
        do_start(base, wpr, rows, stride);
        wait_done("done_timeout", 4000);
        verify(base, wpr, rows, stride, slot_next, aw0, w0, rel0, 1'b1);
        chk("idle_busy", busy, 0);
        slot_next = (slot_next + rows) % 4;
    endtask

    initial begin
        int aw0, w0, rel0, k;
        repeat (3) @(posedge clk);
        #1;
        outputs_zero("reset");
        reset_n = 1'b1;
        tick(2);

        // Single 8-word row
        run_simple(32'h1000, 8, 1, 32'h0);
        // 20-word row splits into 8+8+4
        run_simple(32'h2000, 20, 1, 32'h0);

        // Six rows fed 4 then 2, plus an overflowing row_complete
        aw0 = awa_q.size(); w0 = wd_q.size(); rel0 = rel_cnt;
        feed(4);
        chk("no_ovf_err", wr_error, 0);
        feed(1);
        chk("ovf_err", wr_error, 1);
        do_start(32'h8000, 8, 6, 32'h200);
        chk("start_clears_err", wr_error, 0);
        k = 0;
        while (rel_cnt - rel0 < 4 && k < 2000) begin tick(); k++; end
        chk("four_rows_sent", rel_cnt - rel0, 4);
        tick(10);
        chk("stall_awvalid", awvalid, 0);
        chk("stall_wvalid", wvalid, 0);
        chk("stall_busy", busy, 1);
        feed(2);
        wait_done("done6_timeout", 4000);
        verify(32'h8000, 8, 6, 32'h200, slot_next, aw0, w0, rel0, 1'b1);
        chk("six_err", wr_error, 0);
        slot_next = (slot_next + 6) % 4;

        // Random backpressure, B withheld to hit the outstanding cap
        aw0 = awa_q.size(); w0 = wd_q.size(); rel0 = rel_cnt;
        rnd_mode = 1'b1; b_hold = 1'b1;
        feed(3);
        do_start(32'h20000, 64, 3, 32'h200);
        k = 0;
        while (aw_cnt - b_sent < 15 && k < 3000) begin tick(); k++; end
        tick(40);
        chk("max_outstanding", aw_cnt - b_sent, 15);
        chk("aw_blocked", awvalid, 0);
        b_hold = 1'b0;
        wait_done("done_rnd_timeout", 8000);
        rnd_mode = 1'b0;
        verify(32'h20000, 64, 3, 32'h200, slot_next, aw0, w0, rel0, 1'b0);
        slot_next = (slot_next + 3) % 4;

        // SLVERR on the middle of three bursts
        err_idx = b_sent + 1;
        run_simple(32'h4000, 20, 1, 32'h0);
        chk("bresp_err", wr_error, 1);
        chk("bresp_done", done, 1);
        err_idx = -1;

        // Zero-row job
        aw0 = aw_cnt;
        do_start(32'h5000, 8, 0, 32'h40);
        chk("zero_done_c1", done, 0);
        chk("zero_busy_c1", busy, 1);
        tick();
        chk("zero_done_c2", done, 1);
        chk("zero_err_cleared", wr_error, 0);
        tick(5);
        chk("zero_no_aw", aw_cnt - aw0, 0);

        // Reset in the middle of a data burst, then a clean job
        feed(1);
        do_start(32'h6000, 64, 1, 32'h200);
        k = 0;
        while (!wvalid && k < 100) begin tick(); k++; end
        chk("pre_reset_wvalid", wvalid, 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        outputs_zero("midrst");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        slot_next = 0;
        tick(2);
        run_simple(32'h3000, 8, 2, 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
